// File: rtl/hdmi_pkg.sv
// hdmi_pkg: types and constants shared by the HDMI video framer and its delay line.
package hdmi_pkg;

  typedef enum logic [1:0] {
    CTRL,
    PREAMBLE,
    GUARD,
    VIDEO
  } framer_state_t;

  // CTL3..CTL0 during the video data period preamble
  localparam logic [3:0] CTL_VIDEO_PREAMBLE = 4'b0001;

  localparam int unsigned CH_B = 0;
  localparam int unsigned CH_G = 1;
  localparam int unsigned CH_R = 2;

  typedef struct packed {
    logic        de;
    logic        hsync;
    logic        vsync;
    logic [23:0] px;
  } framer_beat_t;

endpackage

// File: rtl/hdmi_delay_line.sv
// hdmi_delay_line: fixed-depth shift register with synchronous clear.
module hdmi_delay_line #(
  parameter int unsigned WIDTH = 27,
  parameter int unsigned DEPTH = 10
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] r_stage [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= i_data;
      for (int unsigned i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_data = r_stage[DEPTH-1];

endmodule

// File: rtl/hdmi_video_framer.sv
// hdmi_video_framer: delays timing/RGB and inserts the HDMI video preamble and leading guard band.
// Build option HDMI_FRAMER_DVI_MODE_EN: DVI output (no preamble, no guard band, no short-blank flag).
module hdmi_video_framer
  import hdmi_pkg::*;
#(
  parameter int unsigned PREAMBLE_LEN = 8,
  parameter int unsigned GB_LEN       = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [23:0] px_data_i,
  input  logic        de_i,
  input  logic        hsync_i,
  input  logic        vsync_i,
  output logic [23:0] px_data_o,
  output logic        px_data_val_o,
  output logic        gb_o,
  output logic [2:0]  ctl_0_o,
  output logic [2:0]  ctl_1_o,
  output logic        err_short_blank_o
);

  localparam int unsigned LAT = PREAMBLE_LEN + GB_LEN + 1;
  localparam int unsigned CW  = $clog2(LAT);

  framer_beat_t  w_beat_in;
  framer_beat_t  w_dly;
  framer_state_t w_state_nxt;
  logic          w_short;

  logic [23:0]   r_px;
  logic          r_val;
  logic          r_gb;
  logic [2:0]    r_ctl_0;
  logic [2:0]    r_ctl_1;
  logic          r_err;

  assign w_beat_in = '{de: de_i, hsync: hsync_i, vsync: vsync_i, px: px_data_i};

  hdmi_delay_line #(
    .WIDTH ($bits(framer_beat_t)),
    .DEPTH (LAT - 1)
  ) u_dly (
    .i_clk  (clk_i),
    .i_rst  (rst_i),
    .i_data (w_beat_in),
    .o_data (w_dly)
  );

`ifdef HDMI_FRAMER_DVI_MODE_EN
  always_comb begin
    w_state_nxt = w_dly.de ? VIDEO : CTRL;
    w_short     = 1'b0;
  end
`else
  // Window position: LAT on the edge cycle itself, else the counter value.
  // Positions above GB_LEN+1 are preamble, 2..GB_LEN+1 guard band.
  localparam logic [CW:0]   POS_EDGE   = (CW+1)'(LAT);
  localparam logic [CW:0]   POS_GB_TOP = (CW+1)'(GB_LEN + 1);
  localparam logic [CW:0]   POS_WIN_LO = (CW+1)'(2);
  localparam logic [CW-1:0] CNT_LOAD   = CW'(LAT - 1);

  logic          r_de_prev;
  logic [CW-1:0] r_win_cnt;
  logic          w_edge;
  logic [CW:0]   w_pos;
  logic          w_in_win;
  logic          w_in_pre;

  always_comb begin
    w_edge   = de_i & ~r_de_prev;
    w_pos    = w_edge ? POS_EDGE : {1'b0, r_win_cnt};
    w_in_win = (w_pos >= POS_WIN_LO);
    w_in_pre = (w_pos > POS_GB_TOP);
    w_short  = (w_edge && (r_win_cnt != '0)) || (w_dly.de && w_in_win);
    if (w_dly.de)      w_state_nxt = VIDEO;
    else if (w_in_pre) w_state_nxt = PREAMBLE;
    else if (w_in_win) w_state_nxt = GUARD;
    else               w_state_nxt = CTRL;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_de_prev <= 1'b0;
      r_win_cnt <= '0;
    end else begin
      r_de_prev <= de_i;
      if (w_edge)                r_win_cnt <= CNT_LOAD;
      else if (r_win_cnt != '0)  r_win_cnt <= r_win_cnt - CW'(1);
    end
  end
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_px    <= '0;
      r_val   <= 1'b0;
      r_gb    <= 1'b0;
      r_ctl_0 <= '0;
      r_ctl_1 <= '0;
      r_err   <= 1'b0;
    end else begin
      r_px    <= '0;
      r_val   <= 1'b0;
      r_gb    <= 1'b0;
      r_ctl_0 <= {2'b00, w_dly.hsync};
      r_ctl_1 <= {2'b00, w_dly.vsync};
      r_err   <= r_err | w_short;
      unique case (w_state_nxt)
        VIDEO: begin
          r_px  <= w_dly.px;
          r_val <= 1'b1;
        end
        GUARD: r_gb <= 1'b1;
        PREAMBLE: begin
          r_ctl_0[CH_G] <= CTL_VIDEO_PREAMBLE[0];
          r_ctl_1[CH_G] <= CTL_VIDEO_PREAMBLE[1];
          r_ctl_0[CH_R] <= CTL_VIDEO_PREAMBLE[2];
          r_ctl_1[CH_R] <= CTL_VIDEO_PREAMBLE[3];
        end
        default: ;
      endcase
    end
  end

  assign px_data_o         = r_px;
  assign px_data_val_o     = r_val;
  assign gb_o              = r_gb;
  assign ctl_0_o           = r_ctl_0;
  assign ctl_1_o           = r_ctl_1;
  assign err_short_blank_o = r_err;

endmodule

// File: tb/tb_hdmi_video_framer.sv
// tb_hdmi_video_framer: scoreboard bench; a line-history reference model predicts every output cycle.
module tb_hdmi_video_framer;

  localparam int PRE  = 8;
  localparam int GB   = 2;
  localparam int LAT  = PRE + GB + 1;
  localparam int MAXC = 8192;

  typedef struct packed {
    logic        de;
    logic        hs;
    logic        vs;
    logic [23:0] px;
  } tb_beat_t;

  typedef struct {
    int          tag;
    logic [23:0] px;
    logic        val;
    logic        gb;
    logic [2:0]  c0;
    logic [2:0]  c1;
    logic        err;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [23:0] px_data_i = '0;
  logic        de_i = 1'b0;
  logic        hsync_i = 1'b0;
  logic        vsync_i = 1'b0;
  logic [23:0] px_data_o;
  logic        px_data_val_o;
  logic        gb_o;
  logic [2:0]  ctl_0_o;
  logic [2:0]  ctl_1_o;
  logic        err_short_blank_o;

  hdmi_video_framer #(
    .PREAMBLE_LEN (PRE),
    .GB_LEN       (GB)
  ) dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .px_data_i         (px_data_i),
    .de_i              (de_i),
    .hsync_i           (hsync_i),
    .vsync_i           (vsync_i),
    .px_data_o         (px_data_o),
    .px_data_val_o     (px_data_val_o),
    .gb_o              (gb_o),
    .ctl_0_o           (ctl_0_o),
    .ctl_1_o           (ctl_1_o),
    .err_short_blank_o (err_short_blank_o)
  );

  always #5 clk_i = ~clk_i;

  int n_edge = 0;
  always @(posedge clk_i) n_edge <= n_edge + 1;

  int checks = 0;
  int errors = 0;

  exp_t     exp_q[$];
  tb_beat_t hist[MAXC];
  int       last_edge = -1000;
  logic     m_err = 1'b0;

  function automatic tb_beat_t hget(int i);
    if (i < 0) return '0;
    return hist[i];
  endfunction

  // Reference: output at cycle c+1 shows the input from cycle c-10; blank output
  // cycles are classified by distance k from the most recent de rising edge.
  task automatic model_step(input int c, input logic rst, input tb_beat_t b);
    exp_t     e;
    tb_beat_t src;
    logic     edge_c;
    int       eff;
    int       k;
    e = '{tag: c + 1, px: '0, val: 1'b0, gb: 1'b0, c0: '0, c1: '0, err: 1'b0};
    if (rst) begin
      for (int i = c - LAT; i <= c; i++) if (i >= 0) hist[i] = '0;
      last_edge = -1000;
      m_err     = 1'b0;
    end else begin
      hist[c] = b;
      edge_c  = b.de && !hget(c - 1).de;
      src     = hget(c - (LAT - 1));
      eff     = edge_c ? c : last_edge;
      k       = c + 1 - eff;
      if (edge_c && (c - last_edge) <= LAT - 1) m_err = 1'b1;
      if (src.de && k <= PRE + GB)              m_err = 1'b1;
      last_edge = eff;
      e.c0 = {2'b00, src.hs};
      e.c1 = {2'b00, src.vs};
      if (src.de) begin
        e.px  = src.px;
        e.val = 1'b1;
      end
`ifndef HDMI_FRAMER_DVI_MODE_EN
      else if (k <= PRE)      e.c0[1] = 1'b1;
      else if (k <= PRE + GB) e.gb    = 1'b1;
      e.err = m_err;
`endif
    end
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic rst, input logic de, input logic hs, input logic vs,
                       input logic [23:0] px);
    @(posedge clk_i);
    #1;
    rst_i     = rst;
    de_i      = de;
    hsync_i   = hs;
    vsync_i   = vs;
    px_data_i = px;
    model_step(n_edge, rst, '{de: de, hs: hs, vs: vs, px: px});
  endtask

  task automatic blank(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 24'($urandom));
  endtask

  task automatic chk(input string nm, input int cyc, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, req);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (exp_q.size() > 0 && exp_q[0].tag == n_edge) begin
        e = exp_q.pop_front();
        chk("px_data", n_edge, 32'(px_data_o), 32'(e.px));
        chk("px_val",  n_edge, 32'(px_data_val_o), 32'(e.val));
        chk("gb",      n_edge, 32'(gb_o), 32'(e.gb));
        chk("ctl_0",   n_edge, 32'(ctl_0_o), 32'(e.c0));
        chk("ctl_1",   n_edge, 32'(ctl_1_o), 32'(e.c1));
        chk("err",     n_edge, 32'(err_short_blank_o), 32'(e.err));
      end
    end
  end

  initial begin : stim
    logic [23:0] line_px [4];
    line_px[0] = 24'h112233;
    line_px[1] = 24'h445566;
    line_px[2] = 24'h778899;
    line_px[3] = 24'hAABBCC;

    // reset held with de high: release counts as a rising edge
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, 24'h5A5A5A);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, line_px[i]);
    blank(20);

    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, line_px[i]);
    blank(20);

    for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 1'b1, 1'b0, '0);
    blank(3);
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 1'b0, 1'b1, '0);
    blank(20);

    // two lines separated by a 6-cycle gap
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, line_px[i]);
    blank(6);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, ~line_px[i]);
    blank(30);

    // reset pulse on the third active pixel
    drive(1'b0, 1'b1, 1'b0, 1'b0, line_px[0]);
    drive(1'b0, 1'b1, 1'b0, 1'b0, line_px[1]);
    drive(1'b1, 1'b1, 1'b0, 1'b0, line_px[2]);
    drive(1'b0, 1'b1, 1'b0, 1'b0, line_px[3]);
    blank(20);

    for (int l = 0; l < 60; l++) begin
      int nb;
      int nl;
      nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 9)) : int'($urandom_range(10, 24));
      nl = int'($urandom_range(1, 12));
      for (int i = 0; i < nb; i++)
        drive(1'b0, 1'b0, 1'($urandom), 1'($urandom), 24'($urandom));
      for (int i = 0; i < nl; i++)
        drive(($urandom_range(0, 80) == 0), 1'b1, 1'($urandom), 1'($urandom), 24'($urandom));
    end
    blank(20);

    repeat (3) @(posedge clk_i);
    chk("queue_drain", n_edge, 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
